// File: rtl/lut_sequencer_fsm.sv
// LUT-driven sequencer: each entry drives one decoded enable for (rep+1)*max(len,1) cycles.
// Define LUTSEQ_AED_EN to let aed_trigger_i end a code-6 (AED) entry early.
module lut_sequencer_fsm #(
  parameter  int LUT_DEPTH = 16,
  parameter  int LEN_W     = 16,
  parameter  int REP_W     = 8,
  localparam int ADDR_W    = $clog2(LUT_DEPTH),
  localparam int ENTRY_W   = 5 + REP_W + LEN_W + ADDR_W
) (
  input  logic               clk,
  input  logic               reset_n_i,
  input  logic               start_i,
  input  logic               exit_signal_i,
  input  logic               aed_trigger_i,
  input  logic               lut_wen_i,
  input  logic               lut_rden_i,
  input  logic [ADDR_W-1:0]  lut_addr_i,
  input  logic [ENTRY_W-1:0] lut_write_data_i,
  output logic [ENTRY_W-1:0] lut_read_data_o,
  output logic [2:0]         current_state_o,
  output logic               busy_o,
  output logic               sequence_done_o,
  output logic               panel_enable_o,
  output logic               bias_enable_o,
  output logic               flush_enable_o,
  output logic               expose_enable_o,
  output logic               readout_enable_o,
  output logic               aed_enable_o,
  output logic [REP_W-1:0]   current_repeat_count_o,
  output logic [LEN_W-1:0]   current_data_length_o,
  output logic [ADDR_W-1:0]  current_addr_o,
  output logic               current_eof_o,
  output logic               current_sof_o,
  output logic               lut_wr_reject_o
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic              sof;
    logic              eof;
    logic [2:0]        code;
    logic [REP_W-1:0]  rep;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] nxt;
  } entry_t;

`ifdef LUTSEQ_AED_EN
  localparam logic [2:0] TOP_CODE = 3'd6;
`else
  localparam logic [2:0] TOP_CODE = 3'd5;
`endif

  logic [ENTRY_W-1:0] lut_mem [LUT_DEPTH];

  state_t             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  nxt_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   timer_q;
  logic [REP_W-1:0]   rep_cnt_q;
  logic [2:0]         code_q;
  logic [5:0]         en_q;
  logic               sof_q;
  logic               eof_q;
  logic               exit_q;
  logic               busy_q;
  logic               done_q;
  logic               wr_reject_q;
  logic [ENTRY_W-1:0] rd_data_q;

  entry_t fetch_entry;
  logic   in_idle;
  logic   rep_end;
  logic   entry_end;
  logic   aed_end;
  logic   exit_now;

  // A zero-length entry still occupies one cycle per repetition.
  function automatic logic [LEN_W-1:0] at_least_one(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

  function automatic logic [5:0] decode_code(input logic [2:0] code);
    logic [5:0] en;
    en = '0;
    if (code != 3'd0 && code <= TOP_CODE) en[code - 3'd1] = 1'b1;
    return en;
  endfunction

  assign fetch_entry = lut_mem[addr_q];
  assign in_idle     = (state_q == S_IDLE);
  assign rep_end     = (timer_q == LEN_W'(1));
  assign exit_now    = exit_q | exit_signal_i;
  assign entry_end   = (rep_end && rep_cnt_q == '0) || aed_end;

`ifdef LUTSEQ_AED_EN
  assign aed_end = aed_trigger_i && (code_q == 3'd6);
`else
  logic aed_unused;
  assign aed_unused = aed_trigger_i;
  assign aed_end    = 1'b0;
`endif

  // NOTE: LUT storage is deliberately never reset so it maps onto plain RAM and keeps its program across a sequencer reset.
  always_ff @(posedge clk) begin
    if (reset_n_i && in_idle && lut_wen_i) lut_mem[lut_addr_i] <= lut_write_data_i;
  end

  // NOTE: all state updates use <= so every branch sees the pre-edge values of the registers.
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      nxt_q       <= '0;
      len_q       <= '0;
      timer_q     <= '0;
      rep_cnt_q   <= '0;
      code_q      <= '0;
      en_q        <= '0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      exit_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_reject_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      if (!in_idle && exit_signal_i) exit_q <= 1'b1;
      if (!in_idle && lut_wen_i) wr_reject_q <= 1'b1;

      unique case (state_q)
        S_IDLE: begin
          if (lut_rden_i) rd_data_q <= lut_mem[lut_addr_i];
          if (start_i) begin
            state_q     <= S_FETCH;
            addr_q      <= '0;
            exit_q      <= 1'b0;
            wr_reject_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end

        S_FETCH: begin
          sof_q     <= fetch_entry.sof;
          eof_q     <= fetch_entry.eof;
          code_q    <= fetch_entry.code;
          rep_cnt_q <= fetch_entry.rep;
          len_q     <= fetch_entry.len;
          nxt_q     <= fetch_entry.nxt;
          timer_q   <= at_least_one(fetch_entry.len);
          en_q      <= decode_code(fetch_entry.code);
          state_q   <= S_RUN;
        end

        S_RUN: begin
          if (entry_end) begin
            en_q   <= '0;
            code_q <= '0;
            if (!eof_q) begin
              addr_q  <= addr_q + ADDR_W'(1);
              state_q <= S_FETCH;
            end else if (exit_now) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              addr_q  <= nxt_q;
              state_q <= S_FETCH;
            end
          end else if (rep_end) begin
            rep_cnt_q <= rep_cnt_q - REP_W'(1);
            timer_q   <= at_least_one(len_q);
          end else begin
            timer_q <= timer_q - LEN_W'(1);
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          exit_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign lut_read_data_o        = rd_data_q;
  assign current_state_o        = code_q;
  assign busy_o                 = busy_q;
  assign sequence_done_o        = done_q;
  assign panel_enable_o         = en_q[0];
  assign bias_enable_o          = en_q[1];
  assign flush_enable_o         = en_q[2];
  assign expose_enable_o        = en_q[3];
  assign readout_enable_o       = en_q[4];
  assign aed_enable_o           = en_q[5];
  assign current_repeat_count_o = rep_cnt_q;
  assign current_data_length_o  = len_q;
  assign current_addr_o         = addr_q;
  assign current_eof_o          = eof_q;
  assign current_sof_o          = sof_q;
  assign lut_wr_reject_o        = wr_reject_q;

endmodule
